// File: rtl/mux_n_1_rr_if.sv
// Handshake bundle for mux_n_1_rr: N input channels in, one registered channel out.
interface mux_n_1_rr_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_ch;

    // Producer/consumer side (drives inputs, observes outputs)
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // Mux side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_n_1_rr.sv
// N-channel, W-bit registered multiplexer with valid/ready on every channel.
// mode=0: external sel chooses the channel; mode=1: round-robin scan from ptr.
module mux_n_1_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input logic         clk,
    input logic         rst,
    mux_n_1_rr_if.slave bus
);

    logic [W-1:0]    data_q;
    logic [SELW-1:0] ch_q;
    logic            valid_q;
    logic [SELW-1:0] ptr;

    logic            load;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic [W-1:0]    grant_data;
    logic [N-1:0]    ready;

    // Output register can take a word when empty or drained this cycle
    assign load = !valid_q || bus.out_ready;

    // Grant selection; sel values >= N match no channel and so never grant
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (!bus.mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    grant     = SELW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            // Scan ptr, ptr+1, ... wrapping; first valid channel wins
            for (int unsigned k = 0; k < N; k++) begin
                idx = k + 32'(ptr);
                if (idx >= N) idx = idx - N;
                for (int unsigned i = 0; i < N; i++) begin
                    if (!grant_vld && idx == i && bus.in_valid[i]) begin
                        grant     = SELW'(i);
                        grant_vld = 1'b1;
                    end
                end
            end
        end
    end

    // Data of the granted channel and one-hot ready
    always_comb begin
        grant_data = '0;
        ready      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
                ready[i]   = !rst && load && grant_vld;
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (grant_vld) begin
                valid_q <= 1'b1;
                data_q  <= grant_data;
                ch_q    <= grant;
                if (bus.mode)
                    ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed testbench for mux_n_1_rr: a 4-channel instance for the main
// scenarios and a 6-channel instance for out-of-range select.
module tb_mux_n_1_rr;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    mux_n_1_rr_if #(.N(4), .W(8), .SELW(2)) bus ();
    mux_n_1_rr_if #(.N(6), .W(8), .SELW(3)) bus6 ();

    mux_n_1_rr #(.N(4), .W(8), .SELW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mux_n_1_rr #(.N(6), .W(8), .SELW(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel data for the 4-channel instance: ch0=11 ch1=22 ch2=A5 ch3=44
    logic [7:0] d [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        bus.in_data = {d[3], d[2], d[1], d[0]};
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        set_data();
        bus6.mode      = 1'b0;
        bus6.sel       = 3'd0;
        bus6.in_valid  = '1;
        bus6.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) bus6.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        step();
        checks++; if (bus.in_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.out_data); else passes++;
        checks++; if (bus.out_ch !== 2'd0) $display("FAIL reset_ch: got %0d want 0", bus.out_ch); else passes++;
        checks++; if (bus6.out_valid !== 1'b0) $display("FAIL reset_valid6: got %b want 0", bus6.out_valid); else passes++;
        bus6.in_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        bus.mode      = 1'b0;
        bus.sel       = 2'd2;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0100) $display("FAIL fixed_ready: got %b want 0100", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_data !== 8'hA5) $display("FAIL fixed_data: got %h want a5", bus.out_data); else passes++;
        checks++; if (bus.out_ch !== 2'd2) $display("FAIL fixed_ch: got %0d want 2", bus.out_ch); else passes++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL fixed_valid: got %b want 1", bus.out_valid); else passes++;
        // Selected channel goes invalid: no grant, output drains, data holds
        bus.in_valid = 4'b1011;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) $display("FAIL fixed_noval_ready: got %b want 0000", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL fixed_drain_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 8'hA5) $display("FAIL fixed_drain_hold: got %h want a5", bus.out_data); else passes++;
        // 6-channel instance: sel=5 with ch5 invalid
        bus6.in_valid = 6'b011111;
        bus6.sel      = 3'd5;
        #1;
        checks++; if (bus6.in_ready !== 6'b000000) $display("FAIL sel5_ready: got %b want 000000", bus6.in_ready); else passes++;
        step();
        checks++; if (bus6.out_valid !== 1'b0) $display("FAIL sel5_valid: got %b want 0", bus6.out_valid); else passes++;
        // sel beyond N never grants
        bus6.in_valid = 6'b111111;
        bus6.sel      = 3'd6;
        #1;
        checks++; if (bus6.in_ready !== 6'b000000) $display("FAIL sel6_ready: got %b want 000000", bus6.in_ready); else passes++;
        step();
        checks++; if (bus6.out_valid !== 1'b0) $display("FAIL sel6_valid: got %b want 0", bus6.out_valid); else passes++;
        bus6.sel = 3'd4;
        #1;
        checks++; if (bus6.in_ready !== 6'b010000) $display("FAIL sel4_ready: got %b want 010000", bus6.in_ready); else passes++;
        step();
        checks++; if (bus6.out_data !== 8'h14) $display("FAIL sel4_data: got %h want 14", bus6.out_data); else passes++;
        checks++; if (bus6.out_ch !== 3'd4) $display("FAIL sel4_ch: got %0d want 4", bus6.out_ch); else passes++;
        bus6.in_valid = '0;
    endtask

    task automatic test_rr_fairness();
        int exp_all [6] = '{0, 1, 2, 3, 0, 1};
        int exp_odd [4] = '{1, 3, 1, 3};
        pulse_reset();
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (bus.in_ready !== 4'(1 << exp_all[k])) $display("FAIL rr_all_ready[%0d]: got %b want %b", k, bus.in_ready, 4'(1 << exp_all[k])); else passes++;
            step();
            checks++; if (bus.out_ch !== 2'(exp_all[k])) $display("FAIL rr_all_ch[%0d]: got %0d want %0d", k, bus.out_ch, exp_all[k]); else passes++;
            checks++; if (bus.out_data !== d[exp_all[k]]) $display("FAIL rr_all_data[%0d]: got %h want %h", k, bus.out_data, d[exp_all[k]]); else passes++;
        end
        pulse_reset();
        bus.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.out_ch !== 2'(exp_odd[k]) || bus.out_valid !== 1'b1) $display("FAIL rr_odd_ch[%0d]: got ch %0d valid %b want ch %0d valid 1", k, bus.out_ch, bus.out_valid, exp_odd[k]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        bus.mode      = 1'b0;
        bus.sel       = 2'd1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        d[1] = 8'h3C;
        set_data();
        step();
        checks++; if (bus.out_data !== 8'h3C || bus.out_valid !== 1'b1) $display("FAIL bp_load: got %h/%b want 3c/1", bus.out_data, bus.out_valid); else passes++;
        // Next word waits on ch1 while the output is stalled
        d[1] = 8'h5A;
        set_data();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.in_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.in_ready); else passes++;
            step();
            checks++; if (bus.out_data !== 8'h3C || bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1) $display("FAIL bp_hold[%0d]: got %h/%b/%0d want 3c/1/1", k, bus.out_data, bus.out_valid, bus.out_ch); else passes++;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_data !== 8'h5A || bus.out_valid !== 1'b1) $display("FAIL bp_nobubble: got %h/%b want 5a/1", bus.out_data, bus.out_valid); else passes++;
        d[1] = 8'h22;
        set_data();
    endtask

    task automatic test_wrap_skip();
        pulse_reset();
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0100;
        step();
        checks++; if (bus.out_ch !== 2'd2) $display("FAIL wrap_setup_ch: got %0d want 2", bus.out_ch); else passes++;
        // ptr is now 3; only ch0 valid
        bus.in_valid = 4'b0001;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) $display("FAIL wrap_ready: got %b want 0001", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_ch !== 2'd0 || bus.out_data !== 8'h11) $display("FAIL wrap_ch: got %0d/%h want 0/11", bus.out_ch, bus.out_data); else passes++;
        // ptr is now 1; ch0 and ch2 valid -> ch2
        bus.in_valid = 4'b0101;
        #1;
        checks++; if (bus.in_ready !== 4'b0100) $display("FAIL skip_ready: got %b want 0100", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_ch !== 2'd2 || bus.out_data !== 8'hA5) $display("FAIL skip_ch: got %0d/%h want 2/a5", bus.out_ch, bus.out_data); else passes++;
        bus.in_valid = 4'b0000;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) $display("FAIL rr_none_ready: got %b want 0000", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rr_none_valid: got %b want 0", bus.out_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        step();
        step();
        // ptr is 2 and a word is held; a grant is pending on ch2
        checks++; if (bus.out_ch !== 2'd1 || bus.out_valid !== 1'b1) $display("FAIL mid_setup: got ch %0d valid %b want ch 1 valid 1", bus.out_ch, bus.out_valid); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) $display("FAIL mid_first_ready: got %b want 0001", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_ch !== 2'd0 || bus.out_data !== 8'h11) $display("FAIL mid_first_ch: got %0d/%h want 0/11", bus.out_ch, bus.out_data); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'hA5;
        d[3] = 8'h44;
        rst = 1'b1;
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_back_to_back();
        test_wrap_skip();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
